drm_rd_ctrl: RTL and testbench

DRM_RD_CTRL -- requirements
Module: drm_rd_ctrl

---
 rtl/drm_rd_ctrl_if.sv | 11 +
 rtl/drm_rd_ctrl.sv | 79 +++++++
 tb/tb_drm_rd_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/drm_rd_ctrl_if.sv
// drm_rd_ctrl_if: output word stream of the frame read controller
interface drm_rd_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  modport master (output m_data, m_valid, m_last, input m_ready);
  modport slave  (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/drm_rd_ctrl.sv
// drm_rd_ctrl: reads a completed frame from RAM in natural or bit-reversed order and streams it out
module drm_rd_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_rdy,
  input  logic                  bitrev_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_clk_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  drm_rd_ctrl_if.master         m,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  ovf_err
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t                state;
  logic                  brev;
  logic                  inflight;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] ocnt;
  logic [ADDR_WIDTH-1:0] rev;
  logic [DATA_WIDTH-1:0] mem [4];
  logic [1:0]            wp;
  logic [1:0]            rp;
  logic [2:0]            fifo_cnt;
  always_comb begin
    rev = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) rev[i] = cnt[ADDR_WIDTH-1-i];
  end
  // queued words plus the read still in the RAM pipeline never exceed the FIFO depth
  assign rd_clk_en = (state == READ) && ((fifo_cnt + {2'b0, inflight}) < 3'd4);
  assign rd_addr   = brev ? rev : cnt;
  assign m.m_valid = fifo_cnt != 3'd0;
  assign m.m_data  = m.m_valid ? mem[rp] : '0;
  assign m.m_last  = m.m_valid && (ocnt == '1);
  assign pop       = m.m_valid && m.m_ready;
  assign busy      = state != IDLE;
  always_ff @(posedge clk) if (inflight) mem[wp] <= rd_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      brev       <= 1'b0;
      inflight   <= 1'b0;
      cnt        <= '0;
      ocnt       <= '0;
      wp         <= '0;
      rp         <= '0;
      fifo_cnt   <= '0;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      frame_done <= pop && m.m_last;
      ovf_err    <= frame_rdy && (state != IDLE);
      inflight   <= rd_clk_en;
      fifo_cnt   <= fifo_cnt + {2'b0, inflight} - {2'b0, pop};
      if (inflight) wp <= wp + 2'd1;
      if (pop) begin
        rp   <= rp + 2'd1;
        ocnt <= ocnt + 1'b1;
      end
      if (rd_clk_en) cnt <= cnt + 1'b1;
      case (state)
        IDLE: if (frame_rdy) begin
          brev  <= bitrev_en;
          cnt   <= '0;
          ocnt  <= '0;
          state <= READ;
        end
        READ:    if (rd_clk_en && (cnt == '1)) state <= DRAIN;
        DRAIN:   if (pop && m.m_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_drm_rd_ctrl.sv
// tb_drm_rd_ctrl: random-stimulus bench against a frame-level model of the read controller
module tb_drm_rd_ctrl;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int N  = 1 << AW;
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          frame_rdy = 1'b0;
  logic          bitrev_en = 1'b0;
  logic [AW-1:0] rd_addr;
  logic          rd_clk_en;
  logic [DW-1:0] rd_data = '0;
  logic          busy, frame_done, ovf_err;
  logic [DW-1:0] ram [N];
  int            errs = 0;
  int            checks = 0;
  drm_rd_ctrl_if #(.DATA_WIDTH(DW)) s ();
  drm_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_rdy(frame_rdy), .bitrev_en(bitrev_en),
    .rd_addr(rd_addr), .rd_clk_en(rd_clk_en), .rd_data(rd_data), .m(s),
    .busy(busy), .frame_done(frame_done), .ovf_err(ovf_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rd_clk_en) rd_data <= ram[rd_addr];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [AW-1:0] addr_of(input int i, input bit br);
    logic [AW-1:0] a, r;
    a = i[AW-1:0];
    for (int b = 0; b < AW; b++) r[b] = a[AW-1-b];
    return br ? r : a;
  endfunction
  // Model: a frame is a list of N reads; outstanding = issued - popped, words become visible two cycles after issue
  bit active = 0, brev_m = 0, pend_done = 0, pend_ovf = 0, stall_prev = 0, en_x, v_x;
  int issued = 0, issued_prev = 0, popped = 0, obs_pops = 0, obs_ovf = 0;
  logic [DW-1:0] data_prev = '0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_quiet", {busy, rd_clk_en, s.m_valid, s.m_last, frame_done, ovf_err}, 0);
      active = 0; issued = 0; issued_prev = 0; popped = 0;
      pend_done = 0; pend_ovf = 0; stall_prev = 0;
    end else begin
      en_x = active && issued < N && (issued - popped) < 4;
      v_x  = issued_prev > popped;
      chk("busy", busy, active);
      chk("rd_clk_en", rd_clk_en, en_x);
      if (en_x) chk("rd_addr", rd_addr, addr_of(issued, brev_m));
      chk("m_valid", s.m_valid, v_x);
      if (v_x) begin
        chk("m_data", s.m_data, ram[addr_of(popped, brev_m)]);
        chk("m_last", s.m_last, popped == N - 1);
      end
      if (stall_prev) chk("stall_stable", s.m_data, data_prev);
      chk("frame_done", frame_done, pend_done);
      chk("ovf_err", ovf_err, pend_ovf);
      if (s.m_valid && s.m_ready) obs_pops++;
      if (ovf_err) obs_ovf++;
      pend_ovf   = frame_rdy && active;
      pend_done  = v_x && s.m_ready && popped == N - 1;
      stall_prev = v_x && !s.m_ready;
      data_prev  = s.m_data;
      issued_prev = issued;
      if (en_x) issued++;
      if (v_x && s.m_ready) popped++;
      if (pend_done) active = 0;
      else if (frame_rdy && !active) begin
        active = 1; brev_m = bitrev_en; issued = 0; issued_prev = 0; popped = 0;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string nm);
    chk({nm, "_ctl"}, {rd_addr, rd_clk_en, s.m_valid, s.m_last, busy, frame_done, ovf_err}, 0);
    chk({nm, "_data"}, s.m_data, 0);
  endtask
  task automatic start_frame(input bit br);
    bitrev_en = br;
    frame_rdy = 1'b1;
    step();
    frame_rdy = 1'b0;
    bitrev_en = ~br;
  endtask
  task automatic wait_done(input string nm, input bit rnd);
    int k;
    for (k = 0; k < 6000; k++) begin
      s.m_ready = rnd ? 1'($urandom % 2) : 1'b1;
      step();
      if (frame_done) break;
    end
    chk(nm, k < 6000, 1);
  endtask
  task automatic wait_pops(input int n);
    int k;
    for (k = 0; k < 2000 && obs_pops < n; k++) step();
    chk("wait_pops", obs_pops >= n, 1);
  endtask
  // Frame with m_ready held high, recording event cycles relative to the frame_rdy sampling edge
  task automatic run_timed(input bit br);
    int first_en, first_v, last_c, done_c, na;
    logic [AW-1:0] adr [5];
    logic [AW-1:0] last_addr;
    int exp_a [5];
    first_en = 0; first_v = 0; last_c = 0; done_c = 0; na = 0; last_addr = '0;
    s.m_ready = 1'b1;
    start_frame(br);
    for (int c = 1; c <= 530; c++) begin
      @(negedge clk);
      if (rd_clk_en && first_en == 0) first_en = c;
      if (rd_clk_en && na < 5) begin adr[na] = rd_addr; na++; end
      if (rd_clk_en) last_addr = rd_addr;
      if (s.m_valid && first_v == 0) first_v = c;
      if (s.m_last && last_c == 0) last_c = c;
      if (frame_done && done_c == 0) done_c = c;
      step();
    end
    exp_a = br ? '{0, 256, 128, 384, 64} : '{0, 1, 2, 3, 4};
    chk("t_first_rd", first_en, 1);
    chk("t_first_valid", first_v, 3);
    chk("t_last", last_c, 514);
    chk("t_done", done_c, 515);
    chk("n_addr", na, 5);
    for (int i = 0; i < 5; i++) chk("addr_seq", adr[i], exp_a[i]);
    chk("addr_final", last_addr, 511);
  endtask
  initial begin
    s.m_ready = 1'b0;
    for (int i = 0; i < N; i++) ram[i] = i;
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    run_timed(1'b0);
    run_timed(1'b1);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) ram[i] = $urandom;
      obs_pops = 0;
      start_frame(1'($urandom % 2));
      wait_done("bp_done", 1'b1);
      chk("bp_count", obs_pops, N);
    end
    for (int i = 0; i < N; i++) ram[i] = $urandom;
    obs_pops = 0; obs_ovf = 0;
    s.m_ready = 1'b1;
    start_frame(1'b0);
    wait_pops(100);
    frame_rdy = 1'b1;
    step();
    frame_rdy = 1'b0;
    for (int k = 0; k < 1000 && !s.m_last; k++) step();
    frame_rdy = 1'b1;
    step();
    frame_rdy = 1'b0;
    chk("ovf_frame_done", frame_done, 1);
    repeat (20) step();
    chk("ovf_count", obs_ovf, 2);
    chk("ovf_words", obs_pops, N);
    chk("ovf_idle", busy, 0);
    for (int i = 0; i < N; i++) ram[i] = $urandom;
    obs_pops = 0;
    start_frame(1'b1);
    wait_pops(200);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("post_reset_idle", busy, 0);
    for (int i = 0; i < N; i++) ram[i] = i;
    run_timed(1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
